// File: rtl/router_pkg.sv
// Shared router definitions: port/address sizing and packet-receive FSM states.
// DROP_PACKET exists only when ROUTER_FSM_INVALID_ADDR_DROP_EN is defined.
package router_pkg;

   localparam int unsigned ADDR_WIDTH = 2;
   localparam int unsigned NUM_PORTS  = 3;

`ifdef ROUTER_FSM_INVALID_ADDR_DROP_EN
   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      LOAD_PARITY        = 4'd3,
      FIFO_FULL_STATE    = 4'd4,
      LOAD_AFTER_FULL    = 4'd5,
      WAIT_TILL_EMPTY    = 4'd6,
      CHECK_PARITY_ERROR = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;
`else
   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      WAIT_TILL_EMPTY    = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;
`endif

endpackage

// File: rtl/router_fsm.sv
// Packet-receive controller of the 1x3 router: header decode, load sequencing, source stall.
// Optional macro ROUTER_FSM_INVALID_ADDR_DROP_EN discards packets with an out-of-range address.
module router_fsm #(
   parameter int unsigned ADDR_WIDTH = router_pkg::ADDR_WIDTH,
   parameter int unsigned NUM_PORTS  = router_pkg::NUM_PORTS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pkt_valid,
   input  logic [ADDR_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  fifo_empty_0,
   input  logic                  fifo_empty_1,
   input  logic                  fifo_empty_2,
   input  logic                  soft_reset_0,
   input  logic                  soft_reset_1,
   input  logic                  soft_reset_2,
   input  logic                  parity_done,
   input  logic                  low_pkt_valid,
   output logic [ADDR_WIDTH-1:0] fifo_addr,
   output logic                  detect_add,
   output logic                  lfd_state,
   output logic                  ld_state,
   output logic                  laf_state,
   output logic                  full_state,
   output logic                  rst_int_reg,
   output logic                  write_enb_reg,
   output logic                  busy
);

   import router_pkg::*;

   state_t     state;
   state_t     next_state;
   logic [2:0] empty_vec;
   logic [2:0] soft_vec;
   logic       hdr_valid;
   logic       hdr_empty;
   logic       sel_empty;
   logic       sel_soft;

   assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
   assign hdr_valid = 32'(data_in) < NUM_PORTS;

   // Header lookup uses the live address; in-packet lookups use the latched one.
   always_comb begin
      hdr_empty = 1'b0;
      sel_empty = 1'b0;
      sel_soft  = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (i < NUM_PORTS) begin
            if (ADDR_WIDTH'(i) == data_in) begin
               hdr_empty = empty_vec[i];
            end
            if (ADDR_WIDTH'(i) == fifo_addr) begin
               sel_empty = empty_vec[i];
               sel_soft  = soft_vec[i];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= DECODE_ADDRESS;
         fifo_addr <= '0;
      end else begin
         state <= next_state;
         if (state == DECODE_ADDRESS && pkt_valid) begin
            fifo_addr <= data_in;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               if (hdr_valid) begin
                  next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
`ifdef ROUTER_FSM_INVALID_ADDR_DROP_EN
               else begin
                  next_state = DROP_PACKET;
               end
`endif
            end
         end
         LOAD_FIRST_DATA: next_state = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full) begin
               next_state = FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
               next_state = LOAD_PARITY;
            end
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) begin
               next_state = LOAD_AFTER_FULL;
            end
         end
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               next_state = DECODE_ADDRESS;
            end else if (low_pkt_valid) begin
               next_state = LOAD_PARITY;
            end else begin
               next_state = LOAD_DATA;
            end
         end
         LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            if (sel_empty) begin
               next_state = LOAD_FIRST_DATA;
            end
         end
`ifdef ROUTER_FSM_INVALID_ADDR_DROP_EN
         DROP_PACKET: begin
            // Falling pkt_valid marks the parity byte, which is swallowed here.
            if (!pkt_valid) begin
               next_state = DECODE_ADDRESS;
            end
         end
`endif
         default: next_state = DECODE_ADDRESS;
      endcase
      if (sel_soft && state != DECODE_ADDRESS) begin
         next_state = DECODE_ADDRESS;
      end
   end

   always_comb begin
      detect_add    = state == DECODE_ADDRESS;
      lfd_state     = state == LOAD_FIRST_DATA;
      ld_state      = state == LOAD_DATA;
      laf_state     = state == LOAD_AFTER_FULL;
      full_state    = state == FIFO_FULL_STATE;
      rst_int_reg   = state == CHECK_PARITY_ERROR;
      write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                      (state == LOAD_AFTER_FULL);
      busy          = (state == LOAD_FIRST_DATA) || (state == LOAD_PARITY) ||
                      (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                      (state == WAIT_TILL_EMPTY) || (state == CHECK_PARITY_ERROR);
   end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; output bundle {detect_add,lfd,ld,laf,full,rst_int,we,busy}.
// Expectations for the invalid-address case follow ROUTER_FSM_INVALID_ADDR_DROP_EN.
module tb_router_fsm;

   localparam logic [7:0] O_DA   = 8'b1000_0000;
   localparam logic [7:0] O_LFD  = 8'b0100_0001;
   localparam logic [7:0] O_LD   = 8'b0010_0010;
   localparam logic [7:0] O_LAF  = 8'b0001_0011;
   localparam logic [7:0] O_FULL = 8'b0000_1001;
   localparam logic [7:0] O_LP   = 8'b0000_0011;
   localparam logic [7:0] O_CPE  = 8'b0000_0101;
   localparam logic [7:0] O_WTE  = 8'b0000_0001;
   localparam logic [7:0] O_DROP = 8'b0000_0000;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic [1:0] fifo_addr;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy;
   logic [7:0] outs;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, write_enb_reg, busy};

   router_fsm #(.ADDR_WIDTH(2), .NUM_PORTS(3)) dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
      .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .fifo_addr(fifo_addr), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [7:0] exp);
      @(posedge clock);
      #1;
      chk(tag, outs, exp);
   endtask

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      #1;
      chk("reset_outs", outs, O_DA);
      chk("reset_addr", {6'd0, fifo_addr}, 8'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      tick("idle", O_DA);

      // address 1, empty FIFO, three payload bytes
      pkt_valid = 1'b1; data_in = 2'd1;
      tick("a1_lfd", O_LFD);
      chk("a1_addr", {6'd0, fifo_addr}, 8'd1);
      data_in = 2'd0;
      tick("a1_ld1", O_LD);
      tick("a1_ld2", O_LD);
      tick("a1_ld3", O_LD);
      pkt_valid = 1'b0;
      tick("a1_lp", O_LP);
      tick("a1_cpe", O_CPE);
      tick("a1_da", O_DA);
      tick("a1_idle", O_DA);

      // address 2, FIFO not empty for 5 cycles, then full/after-full path
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      for (int i = 0; i < 5; i++) tick("a2_wait", O_WTE);
      chk("a2_addr", {6'd0, fifo_addr}, 8'd2);
      fifo_empty_2 = 1'b1;
      tick("a2_lfd", O_LFD);
      tick("a2_ld", O_LD);
      fifo_full = 1'b1;
      tick("a2_full", O_FULL);
      tick("a2_full_hold", O_FULL);
      fifo_full = 1'b0;
      tick("a2_laf", O_LAF);
      pkt_valid = 1'b0; low_pkt_valid = 1'b1;
      tick("a2_lp", O_LP);
      low_pkt_valid = 1'b0;
      tick("a2_cpe", O_CPE);
      tick("a2_da", O_DA);

      // address 0 waiting; soft reset for other FIFO ignored, own FIFO honoured
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
      tick("a0_wait", O_WTE);
      soft_reset_1 = 1'b1;
      tick("a0_sr1_ignored", O_WTE);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
      tick("a0_sr0_da", O_DA);
      soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
      tick("a0_idle", O_DA);

      // asynchronous reset in the middle of LOAD_DATA
      pkt_valid = 1'b1; data_in = 2'd1;
      tick("rst_lfd", O_LFD);
      tick("rst_ld", O_LD);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_outs", outs, O_DA);
      chk("rst_async_addr", {6'd0, fifo_addr}, 8'd0);
      pkt_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      tick("rst_idle", O_DA);

      // invalid address 3
      pkt_valid = 1'b1; data_in = 2'd3;
`ifdef ROUTER_FSM_INVALID_ADDR_DROP_EN
      tick("a3_drop1", O_DROP);
      tick("a3_drop2", O_DROP);
`else
      tick("a3_stay1", O_DA);
      tick("a3_stay2", O_DA);
`endif
      pkt_valid = 1'b0;
      tick("a3_da", O_DA);
      tick("a3_idle", O_DA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-receive controller of the 1x3 router; sits directly upstream of the three output FIFOs and the input register stage.
- Decodes the 2-bit destination in the header byte, sequences header/payload/parity loading, and stalls the source while the target FIFO is full or still draining.
- Its lfd_state output is the same signal each FIFO samples to tag header bytes.

Parameters:
- ADDR_WIDTH, 2, width of the destination field (header bits [1:0]).
- NUM_PORTS, 3, number of output FIFOs; valid addresses are 0..NUM_PORTS-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  source asserts for header+payload bytes; deasserts on the parity byte.
- data_in  in  2  header address bits [1:0], sampled only in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally by fifo_addr).
- fifo_empty_0/1/2  in  1 each  empty flags of the three FIFOs.
- soft_reset_0/1/2  in  1 each  per-FIFO timeout soft resets.
- parity_done  in  1  register stage has captured the parity byte.
- low_pkt_valid  in  1  register stage saw pkt_valid fall while the FSM was stalled.
- fifo_addr  out  ADDR_WIDTH  latched destination.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes.
- write_enb_reg  out  1  FIFO write qualifier.
- busy  out  1  stall to source.

Behaviour:
- Reset: state DECODE_ADDRESS, fifo_addr 0. Outputs settle to detect_add=1; all other outputs 0; busy=0.
- Addresses: address valid if < NUM_PORTS; fifo_addr is captured on the clock edge when the FSM is in DECODE_ADDRESS with pkt_valid=1.
- Transitions (one per clock):
  - DECODE_ADDRESS:
    - pkt_valid and valid address with fifo_empty[addr]=1 -> LOAD_FIRST_DATA.
    - pkt_valid and valid address with fifo_empty[addr]=0 -> WAIT_TILL_EMPTY.
    - Otherwise stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - Else !pkt_valid -> LOAD_PARITY.
    - Else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - Else low_pkt_valid -> LOAD_PARITY.
    - Else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[fifo_addr] -> LOAD_FIRST_DATA; else stay.
- Soft reset:
  - soft_reset_N with N==fifo_addr, in any state other than DECODE_ADDRESS, forces DECODE_ADDRESS next edge.
  - It has highest priority below reset.
  - soft_reset for a non-selected FIFO is ignored.
- Outputs (Moore, purely decoded from state, no extra latency):
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in all states except DECODE_ADDRESS and LOAD_DATA.
- Reset mid-packet: asynchronous return to DECODE_ADDRESS, fifo_addr 0, within the same cycle.
- Unused state encodings -> DECODE_ADDRESS.

Optional Feature:
- Macro: ROUTER_FSM_INVALID_ADDR_DROP_EN.
- Defined:
  - Header with address >= NUM_PORTS and pkt_valid=1 -> DROP_PACKET.
  - DROP_PACKET: busy=0, write_enb_reg=0, all decodes 0; stays while pkt_valid=1; on pkt_valid=0 absorbs the parity byte and returns to DECODE_ADDRESS next edge.
- Undefined: invalid address leaves the FSM in DECODE_ADDRESS (bytes ignored); DROP_PACKET encoding does not exist.

Decomposition:
- Package router_pkg holds:
  - state typedef/localparams (DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET).
  - ADDR_WIDTH and NUM_PORTS defaults, shared with the FIFO, register and synchronizer stages.
- No sub-module; the next-state and output decode stay in this block.

Test Plan:
- Reset asserted mid-LOAD_DATA -> state DECODE_ADDRESS immediately; detect_add=1, busy=0, fifo_addr=0.
- Header address 1 with fifo_empty_1=1, 3 payload bytes, then pkt_valid=0:
  - required path DECODE->LFD->LD x3->LOAD_PARITY->CHECK_PARITY_ERROR->DECODE.
  - lfd_state high exactly 1 cycle; write_enb_reg high 4 cycles; rst_int_reg high 1 cycle.
- Header address 2 with fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1 for 5 cycles, then LOAD_FIRST_DATA the cycle after fifo_empty_2 rises.
- fifo_full=1 during LOAD_DATA:
  - -> FIFO_FULL_STATE, busy=1, write_enb_reg=0.
  - On fifo_full=0 -> LOAD_AFTER_FULL.
  - With low_pkt_valid=1, parity_done=0 -> LOAD_PARITY.
- soft_reset_0 while in WAIT_TILL_EMPTY for address 0 -> DECODE_ADDRESS next edge; the same pulse on soft_reset_1 -> no effect.
- Header address 3:
  - with ROUTER_FSM_INVALID_ADDR_DROP_EN -> DROP_PACKET, busy=0, write_enb_reg=0, returns to DECODE one cycle after pkt_valid falls.
  - without the macro -> stays in DECODE_ADDRESS throughout.
